// File: rtl/hsi_pixel_sequencer.sv
// Per-pixel sequencer for the HSI vector core: latches a job config, gates each start on FIFO
// readiness, counts pixel completions and traps core errors, timeouts and bad configs.
module hsi_pixel_sequencer #(
  parameter int OP_CODE_WIDTH   = 4,
  parameter int NUM_BANDS_WIDTH = 32,
  parameter int ERR_WIDTH       = 4,
  parameter int PIX_CNT_WIDTH   = 16,
  parameter int TIMEOUT_WIDTH   = 20
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       go_i,
  input  logic                       abort_i,
  input  logic [OP_CODE_WIDTH-1:0]   op_code_i,
  input  logic [NUM_BANDS_WIDTH-1:0] num_bands_i,
  input  logic [PIX_CNT_WIDTH-1:0]   num_pixels_i,
  input  logic [TIMEOUT_WIDTH-1:0]   timeout_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       err_o,
  output logic [1:0]                 err_cause_o,
  output logic [ERR_WIDTH-1:0]       err_code_o,
  output logic [PIX_CNT_WIDTH-1:0]   pixels_done_o,
  output logic [OP_CODE_WIDTH-1:0]   core_op_code_o,
  output logic [NUM_BANDS_WIDTH-1:0] core_num_bands_o,
  output logic                       core_start_o,
  input  logic                       core_pixel_done_i,
  input  logic [ERR_WIDTH-1:0]       core_error_code_i,
  input  logic                       in1_empty_i,
  input  logic                       in2_empty_i,
  input  logic                       out_full_i
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_ERROR = 3'd5;

  localparam logic [1:0] CAUSE_NONE = 2'd0;
  localparam logic [1:0] CAUSE_CORE = 2'd1;
  localparam logic [1:0] CAUSE_TMO  = 2'd2;
  localparam logic [1:0] CAUSE_CFG  = 2'd3;

  logic [2:0]                 state_q, state_d;
  logic [OP_CODE_WIDTH-1:0]   op_q, op_d;
  logic [NUM_BANDS_WIDTH-1:0] bands_q, bands_d;
  logic [PIX_CNT_WIDTH-1:0]   npix_q, npix_d;
  logic [TIMEOUT_WIDTH-1:0]   tmo_q, tmo_d;
  logic [TIMEOUT_WIDTH-1:0]   tcnt_q, tcnt_d;
  logic [PIX_CNT_WIDTH-1:0]   pix_q, pix_d;
  logic [1:0]                 cause_q, cause_d;
  logic [ERR_WIDTH-1:0]       code_q, code_d;
  logic [PIX_CNT_WIDTH-1:0]   pix_inc;
  logic                       fifos_ready;

  assign pix_inc     = pix_q + PIX_CNT_WIDTH'(1);
  assign fifos_ready = !in1_empty_i && !in2_empty_i && !out_full_i;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    bands_d = bands_q;
    npix_d  = npix_q;
    tmo_d   = tmo_q;
    tcnt_d  = tcnt_q;
    pix_d   = pix_q;
    cause_d = cause_q;
    code_d  = code_q;
    // Abort outranks every transition, including a go_i seen in the same IDLE cycle.
    if (abort_i) begin
      state_d = S_IDLE;
      cause_d = CAUSE_NONE;
      code_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (go_i) begin
            op_d    = op_code_i;
            bands_d = num_bands_i;
            npix_d  = num_pixels_i;
            tmo_d   = timeout_i;
            pix_d   = '0;
            if (num_bands_i == '0) begin
              state_d = S_ERROR;
              cause_d = CAUSE_CFG;
            end else if (num_pixels_i == '0) begin
              state_d = S_DONE;
            end else begin
              state_d = S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (fifos_ready) state_d = S_START;
        end
        S_START: begin
          tcnt_d  = '0;
          state_d = S_RUN;
        end
        S_RUN: begin
          tcnt_d = tcnt_q + TIMEOUT_WIDTH'(1);
          // A core error wins over a simultaneous pixel_done; that pixel is not counted.
          if (core_error_code_i != '0) begin
            state_d = S_ERROR;
            cause_d = CAUSE_CORE;
            code_d  = core_error_code_i;
          end else if (core_pixel_done_i) begin
            pix_d   = pix_inc;
            state_d = (pix_inc == npix_q) ? S_DONE : S_WAIT;
          end else if ((tmo_q != '0) && (tcnt_q == tmo_q - TIMEOUT_WIDTH'(1))) begin
            state_d = S_ERROR;
            cause_d = CAUSE_TMO;
          end
        end
        S_DONE:  state_d = S_IDLE;
        S_ERROR: state_d = S_ERROR;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      bands_q <= '0;
      npix_q  <= '0;
      tmo_q   <= '0;
      tcnt_q  <= '0;
      pix_q   <= '0;
      cause_q <= CAUSE_NONE;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      bands_q <= bands_d;
      npix_q  <= npix_d;
      tmo_q   <= tmo_d;
      tcnt_q  <= tcnt_d;
      pix_q   <= pix_d;
      cause_q <= cause_d;
      code_q  <= code_d;
    end
  end

  assign busy_o           = (state_q == S_WAIT) || (state_q == S_START) || (state_q == S_RUN);
  assign done_o           = (state_q == S_DONE);
  assign err_o            = (state_q == S_ERROR);
  assign core_start_o     = (state_q == S_START);
  assign err_cause_o      = cause_q;
  assign err_code_o       = code_q;
  assign pixels_done_o    = pix_q;
  assign core_op_code_o   = op_q;
  assign core_num_bands_o = bands_q;

endmodule
